// File: rtl/reduce_binary_tree_8_1_seq.sv
// Pipelined N-to-1 binary reduction tree: masks invalid lanes, then sums lane pairs
// over registered levels, widening by one bit per level, with merged valid and lane count.
module reduce_binary_tree_8_1_seq #(
  parameter int DATA_WIDTH      = 32,
  parameter int NUM_INPUT_DATA  = 8,
  parameter int NUM_OUTPUT_DATA = 1,
  localparam int NUM_LEVEL = $clog2(NUM_INPUT_DATA),
  localparam int OUT_WIDTH = DATA_WIDTH + NUM_LEVEL,
  localparam int CNT_WIDTH = NUM_LEVEL + 1
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 i_en,
  input  logic [NUM_INPUT_DATA-1:0]            i_valid,
  input  logic [NUM_INPUT_DATA*DATA_WIDTH-1:0] i_data_bus,
  output logic                                 o_valid,
  output logic [NUM_OUTPUT_DATA*OUT_WIDTH-1:0] o_data_bus,
  output logic [CNT_WIDTH-1:0]                 o_count
);

  // All levels are packed back to back into flat vectors; level L starts at *_off(L).
  function automatic int data_off(input int lvl);
    int o;
    o = 0;
    for (int m = 0; m < lvl; m++) o += (NUM_INPUT_DATA >> m) * (DATA_WIDTH + m);
    return o;
  endfunction

  function automatic int cnt_off(input int lvl);
    int o;
    o = 0;
    for (int m = 0; m < lvl; m++) o += (NUM_INPUT_DATA >> m) * (m + 1);
    return o;
  endfunction

  function automatic int vld_off(input int lvl);
    int o;
    o = 0;
    for (int m = 0; m < lvl; m++) o += (NUM_INPUT_DATA >> m);
    return o;
  endfunction

  localparam int DATA_TOT = data_off(NUM_LEVEL + 1);
  localparam int CNT_TOT  = cnt_off(NUM_LEVEL + 1);
  localparam int VLD_TOT  = vld_off(NUM_LEVEL + 1);

  logic [DATA_TOT-1:0] data_q, data_d;
  logic [CNT_TOT-1:0]  cnt_q,  cnt_d;
  logic [VLD_TOT-1:0]  vld_q,  vld_d;

  // Stage 0: invalid lanes are forced to zero so they never reach the adders.
  for (genvar k = 0; k < NUM_INPUT_DATA; k++) begin : g_lane
    assign vld_d[k] = i_en & i_valid[k];
    assign cnt_d[k] = i_en & i_valid[k];
    assign data_d[k*DATA_WIDTH +: DATA_WIDTH] =
      (i_en && i_valid[k]) ? i_data_bus[k*DATA_WIDTH +: DATA_WIDTH] : '0;
  end

  for (genvar l = 1; l <= NUM_LEVEL; l++) begin : g_level
    localparam int NN = NUM_INPUT_DATA >> l;
    localparam int W  = DATA_WIDTH + l;
    localparam int CW = l + 1;
    localparam int PD = data_off(l - 1);
    localparam int CD = data_off(l);
    localparam int PC = cnt_off(l - 1);
    localparam int CC = cnt_off(l);
    localparam int PV = vld_off(l - 1);
    localparam int CV = vld_off(l);
    for (genvar j = 0; j < NN; j++) begin : g_node
      logic [W-1:0]  sum;
      logic [CW-1:0] cnt;
      assign sum = {1'b0, data_q[PD + (2*j)*(W-1)   +: W-1]}
                 + {1'b0, data_q[PD + (2*j+1)*(W-1) +: W-1]};
      assign cnt = {1'b0, cnt_q[PC + (2*j)*(CW-1)   +: CW-1]}
                 + {1'b0, cnt_q[PC + (2*j+1)*(CW-1) +: CW-1]};
      assign data_d[CD + j*W +: W]   = i_en ? sum : '0;
      assign cnt_d[CC + j*CW +: CW]  = i_en ? cnt : '0;
      assign vld_d[CV + j]           = i_en & (vld_q[PV + 2*j] | vld_q[PV + 2*j + 1]);
    end
  end

  // i_en low is a flush: every stage loads zero, same as reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '0;
      cnt_q  <= '0;
      vld_q  <= '0;
    end else begin
      data_q <= data_d;
      cnt_q  <= cnt_d;
      vld_q  <= vld_d;
    end
  end

  assign o_data_bus = data_q[data_off(NUM_LEVEL) +: OUT_WIDTH];
  assign o_count    = cnt_q[cnt_off(NUM_LEVEL) +: CNT_WIDTH];
  assign o_valid    = vld_q[vld_off(NUM_LEVEL)];

endmodule

// File: tb/tb_reduce_binary_tree_8_1_seq.sv
// Directed bench for the 8-to-1 reduction tree: hand-computed vectors plus a
// four-slot expected pipeline for the streaming, flush and reset sequences.
module tb_reduce_binary_tree_8_1_seq;
  localparam int DW = 32;
  localparam int N  = 8;
  localparam int OW = 35;
  localparam int CW = 4;

  logic          clk;
  logic          rst;
  logic          i_en;
  logic [N-1:0]  i_valid;
  logic [N*DW-1:0] i_data_bus;
  logic          o_valid;
  logic [OW-1:0] o_data_bus;
  logic [CW-1:0] o_count;

  reduce_binary_tree_8_1_seq dut (
    .clk(clk), .rst(rst), .i_en(i_en), .i_valid(i_valid), .i_data_bus(i_data_bus),
    .o_valid(o_valid), .o_data_bus(o_data_bus), .o_count(o_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Expected pipeline: slot 3 is what the outputs must show.
  logic          m_v [4];
  logic [OW-1:0] m_s [4];
  logic [CW-1:0] m_c [4];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    logic [OW-1:0] s;
    logic [CW-1:0] c;
    @(posedge clk);
    s = '0;
    c = '0;
    for (int k = 0; k < N; k++)
      if (i_valid[k]) begin
        s = s + OW'(i_data_bus[k*DW +: DW]);
        c = c + 1'b1;
      end
    if (rst || !i_en) begin
      for (int i = 0; i < 4; i++) begin
        m_v[i] = 1'b0; m_s[i] = '0; m_c[i] = '0;
      end
    end else begin
      for (int i = 3; i > 0; i--) begin
        m_v[i] = m_v[i-1]; m_s[i] = m_s[i-1]; m_c[i] = m_c[i-1];
      end
      m_v[0] = (c != 0); m_s[0] = s; m_c[0] = c;
    end
    #1;
    chk("pipe_valid", 64'(o_valid), 64'(m_v[3]));
    chk("pipe_data", 64'(o_data_bus), 64'(m_s[3]));
    chk("pipe_count", 64'(o_count), 64'(m_c[3]));
  endtask

  task automatic set_rand();
    for (int k = 0; k < N; k++) i_data_bus[k*DW +: DW] = $urandom;
    i_valid = N'($urandom_range(0, 255));
  endtask

  task automatic set_all(input logic [DW-1:0] v);
    for (int k = 0; k < N; k++) i_data_bus[k*DW +: DW] = v;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_valid"}, 64'(o_valid), 64'd0);
    chk({tag, "_data"}, 64'(o_data_bus), 64'd0);
    chk({tag, "_count"}, 64'(o_count), 64'd0);
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      m_v[i] = 1'b0; m_s[i] = '0; m_c[i] = '0;
    end
    rst = 1'b1; i_en = 1'b1; set_rand();

    // Reset held with random inputs, then three cycles after release still empty.
    for (int i = 0; i < 3; i++) begin
      set_rand(); tick(); chk_zero("reset_hold");
    end
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_rand(); i_valid = 8'hFF; tick(); chk_zero("post_reset");
    end
    i_valid = '0;
    repeat (4) tick();

    // Full sum of lanes 1..8.
    for (int k = 0; k < N; k++) i_data_bus[k*DW +: DW] = DW'(k + 1);
    i_valid = 8'hFF;
    tick();
    i_valid = '0;
    repeat (3) tick();
    chk("full_valid", 64'(o_valid), 64'd1);
    chk("full_data", 64'(o_data_bus), 64'd36);
    chk("full_count", 64'(o_count), 64'd8);
    tick();
    chk_zero("full_after");

    // Masking and maximum-width sums on back-to-back samples.
    set_all('1); i_valid = 8'b1010_0101;
    tick();
    i_valid = 8'hFF;
    tick();
    i_valid = '0;
    repeat (2) tick();
    chk("mask_data", 64'(o_data_bus), 64'h3_FFFF_FFFC);
    chk("mask_count", 64'(o_count), 64'd4);
    chk("mask_valid", 64'(o_valid), 64'd1);
    tick();
    chk("max_data", 64'(o_data_bus), 64'h7_FFFF_FFF8);
    chk("max_count", 64'(o_count), 64'd8);
    tick();
    chk_zero("max_after");

    // Streaming: 20 back-to-back random samples.
    for (int i = 0; i < 20; i++) begin
      set_rand(); tick();
    end
    i_valid = '0;
    repeat (4) tick();

    // Flush: i_en low only for the sample at index 5.
    for (int i = 0; i < 10; i++) begin
      set_rand(); i_valid = 8'hFF;
      i_en = (i != 5);
      tick();
      if (i >= 5 && i <= 8) chk_zero("flush_slot");
    end
    i_en = 1'b1; i_valid = '0;
    repeat (4) tick();

    // Reset mid-stream at index 4.
    for (int i = 0; i < 10; i++) begin
      set_rand(); i_valid = 8'hFF;
      rst = (i == 4);
      tick();
      if (i >= 4 && i <= 7) chk_zero("rst_slot");
      if (i == 8) chk("rst_resume_valid", 64'(o_valid), 64'd1);
    end
    rst = 1'b0; i_valid = '0;
    repeat (4) tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/reduce_binary_tree_8_1_seq.md
# reduce_binary_tree_8_1_seq

Pipelined 8-to-1 binary reduction tree: the collecting counterpart of the 1-to-8 sequential wire distribution tree in the crossbar. Each cycle it takes up to eight lane words with per-lane valids and sums the valid lanes pairwise over registered tree levels. It emits one widened sum, a merged valid, and a count of contributing lanes. It sits at the gather end of the non-hierarchical crossbar, where partial results from the distribute side are recombined.

## Interface
- DATA_WIDTH, 32, width of one input lane word (arbitrary, ≥1)
- NUM_INPUT_DATA, 8, number of input lanes; power of 2, ≥2
- NUM_OUTPUT_DATA, 1, number of output words; fixed at 1
- Derived: NUM_LEVEL = log2(NUM_INPUT_DATA) (3 at default); OUT_WIDTH = DATA_WIDTH+NUM_LEVEL; CNT_WIDTH = NUM_LEVEL+1

- clk  input  1  single clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- i_valid  input  NUM_INPUT_DATA  per-lane valid; bit k qualifies lane k
- i_data_bus  input  NUM_INPUT_DATA*DATA_WIDTH  lane k at bits [k*DATA_WIDTH +: DATA_WIDTH], unsigned
- o_valid  output  1  registered; high when ≥1 lane of the emerging sample was valid
- o_data_bus  output  OUT_WIDTH  registered unsigned sum of valid lanes of the emerging sample
- o_count  output  CNT_WIDTH  registered number of valid lanes in the emerging sample (0..NUM_INPUT_DATA)
- i_en  input  1  reduction enable; low flushes the pipe

## Operation
- Stage 0, input latch: for each lane, latch data if its i_valid bit is set, else latch zero. Also latch the valid bit, and count bit = valid bit.
- Levels 1..NUM_LEVEL: node j at level L takes children 2j and 2j+1 from level L-1.
  - data = zero-extended sum, widened by 1 bit per level
  - valid = OR of child valids
  - count = sum of child counts
- Level NUM_LEVEL holds one node, which is the output register driving o_data_bus, o_valid, o_count.
- Arithmetic:
  - Unsigned with no truncation: the max sum NUM_INPUT_DATA*(2^DATA_WIDTH-1) fits OUT_WIDTH exactly.
  - Invalid lanes contribute exactly 0 regardless of their data.
- Every register (input latch, intermediate levels, output) follows the same rule each cycle:
  - rst=1 or i_en=0: load zero (data, valid, count)
  - otherwise: load the new value
- i_en low is a flush, not a stall:
  - In-flight samples are discarded.
  - A low pulse of N cycles produces N zero-valued, invalid output slots, offset by the pipeline depth.
- No back-pressure; the downstream consumer must accept every cycle.
- o_valid=0 implies o_data_bus=0 and o_count=0.

## Timing
- Reset: o_valid=0, o_data_bus=0, o_count=0 on the first rising edge with rst=1, held while rst=1.
- Latency: NUM_LEVEL+1 cycles (4 at default).
  - A sample presented at edge t (i_en=1 at t..t+3) appears on outputs after edge t+3 and is usable in cycle t+4.
- Throughput: one sample per cycle. Back-to-back samples emerge on consecutive cycles in order.
- i_en=0 at edge t zeroes every stage at that edge: the sample at any stage is lost. Output reads zero from cycle t+1.
- i_en returning high at edge t+1: the first new sample (input at t+1) emerges after edge t+4.
  - Until then the outputs drain the zeros loaded during the flush.
- rst mid-stream: same as i_en=0, and rst has priority over i_en=1.
- After rst deasserts, the first valid output comes no earlier than NUM_LEVEL+1 edges later.
- All i_valid=0 with i_en=1: a zero/invalid sample propagates normally, indistinguishable from a flush slot.

## Test plan
- Reset: hold rst=1 for 3 cycles with random inputs, i_en=1 -> o_valid=0, o_data_bus=0, o_count=0 every cycle, and for 3 cycles after release.
- Full sum: i_valid=8'hFF, lanes k = k+1 (1..8), i_en=1, one cycle -> exactly 4 cycles later o_valid=1, o_data_bus=36, o_count=8; next cycle zero/invalid.
- Masking and max width: i_valid=8'b1010_0101, all lanes 32'hFFFF_FFFF -> o_data_bus=35'h3_FFFF_FFFC, o_count=4. Then i_valid=8'hFF, all lanes 32'hFFFF_FFFF -> 35'h7_FFFF_FFF8, o_count=8 (no overflow).
- Streaming: 20 consecutive random samples with i_en=1 -> output stream matches a reference model sample-for-sample, shifted 4 cycles, no gaps.
- Flush: stream samples S0..S9 on edges 0..9 with i_en=0 only at edge 5 -> outputs S0,S1 valid; then 4 zero slots where S2..S5 would be (S2..S4 in flight and S5 never latched); then S6..S9 correct.
- Reset mid-stream: rst=1 for one cycle at edge 4 of a random stream -> 4 consecutive zero/invalid output slots (S1..S4), then correct outputs resume from the sample presented at edge 5.
